// File: rtl/hex_display_ctrl_pkg.sv
// Shared mode encodings and seven-segment decode for the hex display controller.
// Pure constants and a combinational helper; no latency, no flow control.
// Segment patterns are active-low {g..a}.
package hex_disp_pkg;

    localparam logic [1:0] MODE_LIVE  = 2'b00;
    localparam logic [1:0] MODE_HOLD  = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_COUNT = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] on_pat;
        case (nib)
            4'h0: on_pat = 7'h3F;
            4'h1: on_pat = 7'h06;
            4'h2: on_pat = 7'h5B;
            4'h3: on_pat = 7'h4F;
            4'h4: on_pat = 7'h66;
            4'h5: on_pat = 7'h6D;
            4'h6: on_pat = 7'h7D;
            4'h7: on_pat = 7'h07;
            4'h8: on_pat = 7'h7F;
            4'h9: on_pat = 7'h6F;
            4'hA: on_pat = 7'h77;
            4'hB: on_pat = 7'h7C;
            4'hC: on_pat = 7'h39;
            4'hD: on_pat = 7'h5E;
            4'hE: on_pat = 7'h79;
            default: on_pat = 7'h71;
        endcase
        return ~on_pat;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Bundles the switch/key inputs and segment outputs of the hex display controller.
// Wiring only; no latency, no flow control.
// master drives value/key/mode, slave (the controller) drives segments and loaded.
interface hex_display_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value_in;
    logic                load_n;
    logic [1:0]          mode;
    logic                lz_blank;
    logic [7*DIGITS-1:0] seg_out;
    logic                loaded;

    modport master (output value_in, load_n, mode, lz_blank, input seg_out, loaded);
    modport slave  (input value_in, load_n, mode, lz_blank, output seg_out, loaded);
endinterface

// File: rtl/hex_display_ctrl_debounce.sv
// Synchronises and debounces a raw active-low key; emits the level and a press pulse.
// Latency: 2 sync cycles plus DEB_CYCLES stable samples; press pulse is registered.
// No backpressure; any sample matching the current level restarts the window.
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync_1, sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync_2;
                press <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low hex display with live/hold/blink/count modes and zero blanking.
// Latency: value_in to seg_out 2 cycles; key press to loaded 2+DEB_CYCLES+1 cycles.
// No backpressure; outputs are free-running registers.
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    hex_display_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic              key_level, key_press, press_evt;
    logic [W-1:0]      hold, src;
    logic [BW-1:0]     blink_cnt;
    logic              blink_phase;
    logic              seen_nz;
    logic [7*DIGITS-1:0] seg_nxt;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (CLOCK_50),
        .rst   (RESET),
        .key_n (bus.load_n),
        .level (key_level),
        .press (key_press)
    );

    assign press_evt = key_press & ~key_level;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hold        <= '0;
            src         <= '0;
            bus.loaded  <= 1'b0;
            bus.seg_out <= '1;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            bus.loaded <= press_evt;
            if (press_evt) begin
                if (bus.mode == MODE_HOLD || bus.mode == MODE_BLINK)
                    hold <= bus.value_in;
                else if (bus.mode == MODE_COUNT)
                    hold <= hold + W'(1);
            end
            src <= (bus.mode == MODE_LIVE) ? bus.value_in : hold;
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
            bus.seg_out <= seg_nxt;
        end
    end

    // Scan from the top digit down; once a nonzero digit is seen all lower digits show.
    always_comb begin
        seen_nz = 1'b0;
        seg_nxt = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen_nz = seen_nz | (src[4*i +: 4] != 4'h0);
            if (seen_nz || i == 0 || !bus.lz_blank)
                seg_nxt[7*i +: 7] = hex_to_seg(src[4*i +: 4]);
            else
                seg_nxt[7*i +: 7] = SEG_BLANK;
        end
        if (bus.mode == MODE_BLINK && !blink_phase)
            seg_nxt = '1;
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with DIGITS=4, DEB_CYCLES=8, BLINK_DIV=4.
module tb_hex_display_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_loaded = 0;

    hex_display_ctrl_if #(.DIGITS(4)) bus ();

    hex_display_ctrl #(.DIGITS(4), .DEB_CYCLES(8), .BLINK_DIV(4)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.loaded) n_loaded++;

    localparam logic [31:0] BLANK4 = 32'h0FFFFFFF;
    localparam logic [31:0] ZERO4  = {4'h0, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press_key();
        bus.load_n = 1'b0;
        tick(12);
        bus.load_n = 1'b1;
        tick(12);
    endtask

    function automatic logic [31:0] segs();
        return {4'h0, bus.seg_out};
    endfunction

    initial begin
        int base;
        int n;
        logic [31:0] vis;

        bus.value_in = 16'h0000;
        bus.load_n   = 1'b1;
        bus.mode     = 2'b00;
        bus.lz_blank = 1'b0;
        tick(3);
        chk("reset_seg", segs(), BLANK4);
        chk("reset_loaded", {31'd0, bus.loaded}, 32'd0);
        rst = 1'b0;
        tick(2);
        chk("live_zero", segs(), ZERO4);

        // Live path and latency
        bus.value_in = 16'hB0D5;
        tick(1);
        chk("live_lat1", segs(), ZERO4);
        tick(1);
        chk("live_b0d5", segs(), {4'h0, 7'h03, 7'h40, 7'h21, 7'h12});
        bus.lz_blank = 1'b1;
        tick(2);
        chk("lz_b0d5", segs(), {4'h0, 7'h03, 7'h40, 7'h21, 7'h12});
        bus.value_in = 16'h0005;
        tick(2);
        chk("lz_0005", segs(), {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h12});
        bus.value_in = 16'h0000;
        tick(2);
        chk("lz_0000", segs(), {4'h0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        bus.value_in = 16'h0A00;
        tick(2);
        chk("lz_0a00", segs(), {4'h0, 7'h7F, 7'h08, 7'h40, 7'h40});
        bus.lz_blank = 1'b0;

        // Hold mode: glitch ignored, clean press loads
        bus.mode     = 2'b01;
        bus.value_in = 16'h1234;
        tick(2);
        chk("hold_init", segs(), ZERO4);
        bus.load_n = 1'b0;
        tick(5);
        bus.load_n = 1'b1;
        tick(20);
        chk("glitch_no_load", n_loaded, 0);
        chk("glitch_hold", segs(), ZERO4);

        bus.load_n = 1'b0;
        tick(10);
        chk("press_pre", {31'd0, bus.loaded}, 32'd0);
        tick(1);
        chk("press_lat", {31'd0, bus.loaded}, 32'd1);
        tick(1);
        chk("press_pulse_end", {31'd0, bus.loaded}, 32'd0);
        tick(1);
        chk("hold_1234", segs(), {4'h0, 7'h79, 7'h24, 7'h30, 7'h19});
        tick(7);
        bus.load_n = 1'b1; tick(3);
        bus.load_n = 1'b0; tick(2);
        bus.load_n = 1'b1; tick(3);
        bus.load_n = 1'b0; tick(1);
        bus.load_n = 1'b1; tick(20);
        chk("bounce_one_pulse", n_loaded, 1);

        // Count mode wrap
        bus.value_in = 16'hFFFE;
        press_key();
        chk("preset_fffe", segs(), {4'h0, 7'h0E, 7'h0E, 7'h0E, 7'h06});
        bus.mode     = 2'b11;
        bus.value_in = 16'h1234;
        press_key();
        chk("count_ffff", segs(), {4'h0, 7'h0E, 7'h0E, 7'h0E, 7'h0E});
        press_key();
        chk("count_0000", segs(), ZERO4);
        press_key();
        chk("count_0001", segs(), {4'h0, 7'h40, 7'h40, 7'h40, 7'h79});
        chk("count_pulses", n_loaded, 5);

        // Blink
        bus.mode     = 2'b01;
        bus.value_in = 16'h00A5;
        press_key();
        vis = {4'h0, 7'h40, 7'h40, 7'h08, 7'h12};
        bus.mode = 2'b10;
        n = 0;
        while (segs() != BLANK4 && n < 12) begin tick(1); n++; end
        chk("blink_find_blank", segs(), BLANK4);
        n = 0;
        while (segs() == BLANK4 && n < 12) begin tick(1); n++; end
        chk("blink_find_vis", segs(), vis);
        for (int k = 1; k < 16; k++) begin
            tick(1);
            chk($sformatf("blink_%0d", k), segs(), ((k / 4) % 2 == 0) ? vis : BLANK4);
        end
        bus.mode = 2'b01;
        tick(2);
        chk("steady_a", segs(), vis);
        tick(4);
        chk("steady_b", segs(), vis);

        // Reset in the middle of a debounce window
        base = n_loaded;
        bus.load_n = 1'b0;
        tick(8);
        rst = 1'b1;
        tick(1);
        chk("rst_seg", segs(), BLANK4);
        chk("rst_loaded", {31'd0, bus.loaded}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("rst_hold_zero", segs(), ZERO4);
        chk("rst_no_pulse", n_loaded, base);
        tick(8);
        chk("rst_full_window", {31'd0, bus.loaded}, 32'd0);
        tick(1);
        chk("rst_press_late", {31'd0, bus.loaded}, 32'd1);
        bus.load_n = 1'b1;
        tick(2);
        chk("rst_reload", segs(), vis);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
